// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises raw lines, deframes 11-bit frames, folds E0/F0 prefixes into flags and queues codes.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN; out_valid rises one clk after the stop-bit edge.
module ps2_scan_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_brk,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err_pulse,
  output logic       ovf_pulse,
  output logic [7:0] err_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   fall;
  logic                   bit_in;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          parity_ok;
  logic          stop_ok;
  logic          frame_done;
  logic          frame_good;
  logic          frame_err;
  logic          is_e0;
  logic          is_f0;
  logic          push;

  logic          ext_pend;
  logic          brk_pend;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          push_ok;

  // Idle-high reset value keeps a released reset from looking like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign fall   = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
  assign bit_in = dat_sync[SYNC_STAGES-1];

  assign timeout = (state != IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit <= 1'b0;
    end else if (fall && state == PARITY) begin
      par_bit <= bit_in;
    end
  end

  assign parity_ok = ^{shift_reg, par_bit};
`else
  // The parity bit is still clocked through the PARITY state, its value is simply not judged.
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      timer     <= '0;
    end else if (timeout) begin
      state <= IDLE;
      timer <= '0;
    end else if (fall) begin
      timer <= '0;
      case (state)
        IDLE: begin
          if (!bit_in) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          shift_reg <= {bit_in, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= PARITY;
        end
        PARITY:  state <= STOP;
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end else if (state != IDLE) begin
      timer <= timer + 1'b1;
    end
  end

  assign stop_ok    = bit_in & parity_ok;
  assign frame_done = fall && (state == STOP);
  assign frame_good = frame_done & stop_ok;
  assign frame_err  = timeout | (frame_done & ~stop_ok);
  assign is_e0      = (shift_reg == 8'hE0);
  assign is_f0      = (shift_reg == 8'hF0);
  assign push       = frame_good & ~is_e0 & ~is_f0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (frame_good && is_e0) begin
        ext_pend <= 1'b1;
      end else if (frame_good && is_f0) begin
        brk_pend <= 1'b1;
      end else if (push) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
      err_pulse <= frame_err;
      if (frame_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = out_valid & out_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{ext: ext_pend, brk: brk_pend, code: shift_reg};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf_pulse <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf_pulse <= push & full & ~pop;
    end
  end

  assign out_valid = (count != '0);
  assign head      = mem[rd_ptr];
  assign out_code  = out_valid ? head.code : 8'd0;
  assign out_ext   = out_valid & head.ext;
  assign out_brk   = out_valid & head.brk;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for ps2_clk and ps2_data, legal range 2..4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output queue entries, power of 2, legal range 2..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000: clk cycles allowed between falling edges inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have ports ps2_clk and ps2_data, inputs, 1 bit each: raw asynchronous PS/2 lines.
REQ-007 SHALL have port out_code, output, 8 bits: scan code at the FIFO head.
REQ-008 SHALL have ports out_ext and out_brk, outputs, 1 bit each: E0 prefix seen and F0 (release) prefix seen for the head entry.
REQ-009 SHALL have ports out_valid (output) and out_ready (input), 1 bit each: consumer handshake.
REQ-010 SHALL have ports err_pulse and ovf_pulse, outputs, 1 bit each: one-cycle frame-error and FIFO-overflow strobes.
REQ-011 SHALL have port err_count, output, 8 bits: saturating count of frame errors.

Function
REQ-012 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each and detect a falling edge when the last stage is 1 and the stage before it is 0.
REQ-013 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on detected falling edges.
REQ-014 In IDLE, an edge with data=0 SHALL enter DATA with bit count 0; an edge with data=1 SHALL be ignored.
REQ-015 In DATA, the FSM SHALL shift in 8 bits LSB first, then enter PARITY; PARITY SHALL capture one bit, then enter STOP.
REQ-016 In STOP, data=1 (plus parity check per REQ-029) SHALL make the frame good; anything else SHALL be a frame error; both outcomes return to IDLE.
REQ-017 Outside IDLE, a timer SHALL reset on every edge; reaching TIMEOUT_CYCLES SHALL abort to IDLE and count as a frame error.
REQ-018 A frame error SHALL assert err_pulse for exactly one cycle, increment err_count saturating at 255, and leave prefix flags unchanged.
REQ-019 A good byte 0xE0 SHALL set ext_pend; a good byte 0xF0 SHALL set brk_pend; neither is pushed to the FIFO.
REQ-020 Any other good byte SHALL push {ext_pend, brk_pend, byte} and clear both pend flags in the same cycle.
REQ-021 out_valid SHALL equal FIFO not-empty; a push into an empty FIFO SHALL give out_valid=1 on the next clk edge.
REQ-022 A pop SHALL occur on a clk edge with out_valid and out_ready both 1; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Push while full without a pop in the same cycle SHALL drop the entry and pulse ovf_pulse for one cycle; push and pop in the same cycle while full SHALL both succeed.
REQ-024 Push and pop in the same cycle at any other occupancy SHALL leave the count unchanged.

Reset
REQ-025 rst=1 SHALL immediately force: FSM IDLE, all synchroniser stages 1, FIFO empty, pend flags 0, timer 0, err_count 0.
REQ-026 During reset, out_valid, out_code, out_ext, out_brk, err_pulse and ovf_pulse SHALL all be 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after reset, reception SHALL resume at the next start bit.

Configuration
REQ-028 The macro PS2_PARITY_CHECK_EN SHALL select whether the parity bit is checked.
REQ-029 With PS2_PARITY_CHECK_EN defined, a frame SHALL be good only if the 8 data bits plus the parity bit contain an odd number of ones; otherwise it is a frame error.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored.

Verification
REQ-031 Send 0x1C with parity 0, stop 1: out_code=0x1C, ext=0, brk=0, out_valid=1 one clk after the stop-bit edge.
REQ-032 Send F0 then 1C: single entry with code=0x1C, brk=1, ext=0; send E0, F0, 75: code=0x75, ext=1, brk=1.
REQ-033 With the macro defined, send 0x1C with parity 1: no push, err_pulse once, err_count=1; without the macro, 0x1C is pushed.
REQ-034 Send 3 bits, then idle for TIMEOUT_CYCLES: err_pulse once, FSM back in IDLE; the next full frame is received correctly.
REQ-035 Hold out_ready=0 and send FIFO_DEPTH+1 codes: first FIFO_DEPTH are kept in order, ovf_pulse once, last code dropped.
REQ-036 Assert rst after the 5th data edge: out_valid=0, err_count=0; a frame 0x29 afterwards yields out_code=0x29.
